// File: rtl/i2c_reg_slave.sv
// I2C slave exposing NUM_REGS byte registers with pointer addressing and auto-increment (reads and writes).
// SCL/SDA are synchronised (3 clk latency); SDA never changes except the cycle after a detected SCL fall; no clock stretching.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 4,
    parameter int         DATA_W     = 8,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i2c_scl,
    input  logic                       i2c_sda_in,
    output logic                       i2c_sda_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    output logic                       wr_strobe,
    output logic [PTR_W-1:0]           wr_index,
    output logic                       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt, w_rx_byte, w_rd_cur, w_rd_next;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt, w_ptr_inc, r_wr_index;
    logic                r_sda_oe, w_oe_nxt, r_busy, w_busy_nxt, w_wr_en, r_wr_strobe;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [1:0]          r_scl_sync, r_sda_sync;
    logic                r_scl_hist, r_sda_hist;
    logic                w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronisers idle high so reset release never looks like a bus condition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda_in};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

    assign w_rx_byte = {r_shift[DATA_W-2:0], w_sda};
    assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_rd_cur  = r_regs[r_ptr];
    assign w_rd_next = r_regs[w_ptr_inc];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_sda_oe;
        w_busy_nxt  = r_busy;
        w_wr_en     = 1'b0;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        w_wr_en     = (r_state == ST_WDATA) && (r_cnt == 4'd7);
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_nxt = '0;
                        if (r_state == ST_ADDR) begin
                            // General call (address 0) is never acknowledged
                            if (r_shift[DATA_W-1:1] == SLAVE_ADDR && r_shift[DATA_W-1:1] != '0) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_oe_nxt    = 1'b1;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (r_state == ST_PTR) begin
                            if ({1'b0, r_shift} < (DATA_W+1)'(NUM_REGS)) begin
                                w_state_nxt = ST_PTR_ACK;
                                w_ptr_nxt   = r_shift[PTR_W-1:0];
                                w_oe_nxt    = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end else begin
                            w_state_nxt = ST_WDATA_ACK;
                            w_oe_nxt    = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = '0;
                        if (r_shift[0]) begin
                            w_state_nxt = ST_RDATA;
                            w_shift_nxt = w_rd_cur;
                            w_oe_nxt    = ~w_rd_cur[DATA_W-1];
                        end else begin
                            w_state_nxt = ST_PTR;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt = ST_WDATA;
                        w_oe_nxt    = 1'b0;
                        if (r_state == ST_WDATA_ACK) w_ptr_nxt = w_ptr_inc;
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_state_nxt = ST_RACK;
                        w_oe_nxt    = 1'b0;
                    end else if (w_scl_fall) begin
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                        w_oe_nxt    = ~r_shift[DATA_W-2];
                    end
                end
                ST_RACK: begin
                    // cnt = 9 marks a master ACK seen on the 9th rising edge
                    if (w_scl_rise) begin
                        if (w_sda) w_state_nxt = ST_IGNORE;
                        else       w_cnt_nxt   = 4'd9;
                    end else if (w_scl_fall && r_cnt == 4'd9) begin
                        w_state_nxt = ST_RDATA;
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                        w_shift_nxt = w_rd_next;
                        w_oe_nxt    = ~w_rd_next[DATA_W-1];
                    end
                end
                default: begin
                    w_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sda_oe    <= w_oe_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) r_wr_index <= r_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_ptr] <= w_rx_byte;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign i2c_sda_oe = r_sda_oe;
    assign busy       = r_busy;
    assign wr_strobe  = r_wr_strobe;
    assign wr_index   = r_wr_index;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, reference register model, write scoreboard on wr_strobe.
module tb_i2c_reg_slave;
    localparam int Q = 5;

    logic        clk = 1'b0;
    logic        rst_n, scl_m, sda_m;
    logic        sda_oe, wr_strobe, busy;
    logic [31:0] reg_flat;
    logic [1:0]  wr_index;
    logic        sda_bus;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_reg_slave #(.SLAVE_ADDR(7'h42), .NUM_REGS(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(rst_n), .i2c_scl(scl_m), .i2c_sda_in(sda_bus),
        .i2c_sda_oe(sda_oe), .reg_flat(reg_flat), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        bit         a_ack;
        bit         p_ack;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] dat;
    } sb_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    sb_t        sb_q[$];
    sb_t        sb_e;
    logic [7:0] model_regs [4];
    logic [1:0] model_ptr;
    vec_t       vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~mack);
        sda_m = 1'b1;
    endtask

    // Write transfer: START, addr, ptr, n data bytes, STOP; acks and register effects predicted by the model
    task automatic run_write(input vec_t v, input string tag);
        logic ack;
        logic [7:0] d;
        i2c_start();
        send_byte(v.addr, ack);
        check({tag, " addr ack"}, ack, v.a_ack);
        check({tag, " busy after addr"}, busy, v.a_ack);
        send_byte(v.ptr, ack);
        check({tag, " ptr ack"}, ack, v.p_ack);
        if (v.p_ack) model_ptr = v.ptr[1:0];
        for (int k = 0; k < v.n; k++) begin
            d = (k == 0) ? v.d0 : v.d1;
            if (v.p_ack) begin
                sb_q.push_back('{idx: model_ptr, dat: d});
                model_regs[model_ptr] = d;
                model_ptr = model_ptr + 2'd1;
            end
            send_byte(d, ack);
            check($sformatf("%s data%0d ack", tag, k), ack, v.p_ack);
        end
        i2c_stop();
        check({tag, " busy after stop"}, busy, 1'b0);
        check({tag, " sda released"}, sda_oe, 1'b0);
        check({tag, " reg_flat"}, reg_flat, model_flat());
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected wr_strobe: index %0d, none expected", wr_index);
            end else begin
                sb_e = sb_q.pop_front();
                check("wr_index", wr_index, sb_e.idx);
                check("written byte", reg_flat[int'(sb_e.idx)*8 +: 8], sb_e.dat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        vec_t       v;

        vecs[0] = '{addr: 8'h84, ptr: 8'h01, d0: 8'hA5, d1: 8'h00, n: 1, a_ack: 1'b1, p_ack: 1'b1};
        vecs[1] = '{addr: 8'h84, ptr: 8'h03, d0: 8'h11, d1: 8'h22, n: 2, a_ack: 1'b1, p_ack: 1'b1};
        vecs[2] = '{addr: 8'h90, ptr: 8'h01, d0: 8'h55, d1: 8'h00, n: 1, a_ack: 1'b0, p_ack: 1'b0};
        vecs[3] = '{addr: 8'h84, ptr: 8'h00, d0: 8'h3C, d1: 8'h00, n: 1, a_ack: 1'b1, p_ack: 1'b1};
        vecs[4] = '{addr: 8'h84, ptr: 8'h07, d0: 8'h99, d1: 8'h77, n: 2, a_ack: 1'b1, p_ack: 1'b0};
        vecs[5] = '{addr: 8'h00, ptr: 8'h00, d0: 8'hFF, d1: 8'h00, n: 1, a_ack: 1'b0, p_ack: 1'b0};
        vecs[6] = '{addr: 8'h84, ptr: 8'h02, d0: 8'h5A, d1: 8'h6B, n: 2, a_ack: 1'b1, p_ack: 1'b1};

        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        model_ptr = 2'd0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b0;
        tick(4);
        check("reset sda_oe", sda_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset wr_strobe", wr_strobe, 1'b0);
        check("reset wr_index", wr_index, 2'd0);
        check("reset reg_flat", reg_flat, 32'h0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) run_write(vecs[i], $sformatf("row%0d", i));

        // Set pointer to 2, repeated START into a read of three bytes (ACK, ACK, NACK)
        i2c_start();
        send_byte(8'h84, ack); check("rd addrW ack", ack, 1'b1);
        send_byte(8'h02, ack); check("rd ptr ack", ack, 1'b1);
        model_ptr = 2'd2;
        i2c_start();
        send_byte(8'h85, ack); check("rd addrR ack", ack, 1'b1);
        for (int k = 0; k < 3; k++) begin
            recv_byte(k < 2, rd);
            check($sformatf("rd byte%0d", k), rd, model_regs[model_ptr]);
            if (k < 2) model_ptr = model_ptr + 2'd1;
        end
        check("sda released after nack", sda_oe, 1'b0);
        i2c_stop();
        check("busy after read", busy, 1'b0);

        // Read without a pointer phase resumes at the retained pointer
        i2c_start();
        send_byte(8'h85, ack); check("rd2 addr ack", ack, 1'b1);
        recv_byte(1'b0, rd);
        check("rd2 byte", rd, model_regs[model_ptr]);
        i2c_stop();

        // STOP after a partial data byte leaves registers alone
        i2c_start();
        send_byte(8'h84, ack); check("partial addr ack", ack, 1'b1);
        send_byte(8'h01, ack); check("partial ptr ack", ack, 1'b1);
        model_ptr = 2'd1;
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        i2c_stop();
        check("partial reg_flat", reg_flat, model_flat());
        check("partial busy", busy, 1'b0);

        // Prepare reg1 = 0x12 (MSB 0) and pointer 1, then reset during its read
        v = '{addr: 8'h84, ptr: 8'h01, d0: 8'h12, d1: 8'h00, n: 1, a_ack: 1'b1, p_ack: 1'b1};
        run_write(v, "prep");
        v = '{addr: 8'h84, ptr: 8'h01, d0: 8'h00, d1: 8'h00, n: 0, a_ack: 1'b1, p_ack: 1'b1};
        run_write(v, "prep ptr");
        i2c_start();
        send_byte(8'h85, ack); check("rst addr ack", ack, 1'b1);
        scl_m = 1'b1;
        tick(2);
        check("rdata drives low bit", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset sda_oe", sda_oe, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset reg_flat", reg_flat, 32'h0);
        sda_m = 1'b1;
        tick(4);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        model_ptr = 2'd0;
        tick(4);

        i2c_start();
        send_byte(8'h85, ack); check("post-reset addr ack", ack, 1'b1);
        recv_byte(1'b0, rd);
        check("post-reset read", rd, model_regs[model_ptr]);
        i2c_stop();

        tick(4);
        check("scoreboard drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
Parametrised I2C slave that replaces the single fixed-function LED-counter slave with a generic register bank.
- NUM_REGS registers of DATA_W bits each.
- Programmable 7-bit device address.
- Register-pointer addressing, auto-increment, and full read and write transfers.
- Sits on the shared SCL/SDA bus beside i2c_master in top_level. Register contents go out flat to drive LEDs and other fabric logic.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit I2C device address matched after START.
- NUM_REGS, 4, number of registers (2..256).
- DATA_W, 8, register width; fixed at 8 for I2C byte framing, kept for readability.
- PTR_W, $clog2(NUM_REGS), internal pointer width.

Ports:
- clk  input  1  system clock; must be at least 10x the SCL frequency.
- reset_n  input  1  asynchronous active-low reset.
- i2c_scl  input  1  bus SCL, sampled only; this block never stretches the clock.
- i2c_sda_in  input  1  bus SDA sampled value.
- i2c_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- reg_flat  output  NUM_REGS*DATA_W  all registers concatenated; reg 0 sits in the LSBs.
- wr_strobe  output  1  one-cycle pulse when a byte is committed to a register.
- wr_index  output  PTR_W  index of the register written; valid while wr_strobe = 1.
- busy  output  1  high from address match until STOP or non-matching START.

Behaviour:
Reset values (asynchronous on reset_n = 0):
- All registers, i2c_sda_oe, wr_strobe, wr_index, busy and the pointer reset to 0.
- State resets to IDLE.
- Reset mid-transfer releases SDA in the same edge.

Input conditioning:
- SCL and SDA pass through 2-FF synchronizers plus one history FF.
- Edges and conditions are detected on synchronized values, giving 3 clk of latency.
- START: SDA 1->0 while SCL = 1.
- STOP: SDA 0->1 while SCL = 1.
- START/STOP take priority over any data edge in the same cycle.

Timing rules:
- Data is sampled on SCL rising edges.
- i2c_sda_oe changes only in the cycle after a detected SCL falling edge.

States:
- IDLE
- ADDR: shift 8 bits.
- ADDR_ACK
- PTR: shift 8 bits.
- PTR_ACK
- WDATA: shift 8 bits.
- WDATA_ACK
- RDATA: drive 8 bits, MSB first.
- RACK: sample master ACK.
- IGNORE: wait for STOP/START.

Transitions:
- START from any state -> ADDR, bit counter = 0. This covers repeated START.
- STOP from any state -> IDLE, busy = 0, SDA released.
- ADDR, after 8 bits:
  - addr[7:1] != SLAVE_ADDR -> IGNORE, no ACK.
  - Match -> ADDR_ACK with SDA driven low for one SCL period; busy = 1.
- ADDR_ACK, R/W = 0 -> PTR.
- ADDR_ACK, R/W = 1 -> RDATA, with the shift register loaded from reg[pointer] when ACK is released.
- PTR, after 8 bits:
  - value < NUM_REGS -> load pointer, ACK, -> PTR_ACK -> WDATA.
  - value >= NUM_REGS -> NACK (SDA released), pointer unchanged, -> IGNORE.
- WDATA, after 8 bits:
  - reg[pointer] <= byte.
  - wr_strobe = 1 for exactly one clk with wr_index = pointer, asserted on the 8th SCL rising edge.
  - ACK, then pointer increments.
- RDATA, after 8 bits -> RACK.
  - Master ACK (SDA = 0): pointer increments, next byte loads, -> RDATA.
  - Master NACK: -> IGNORE, SDA released.

Pointer wrap:
- Increment from NUM_REGS-1 wraps to 0, for both reads and writes.

Other rules:
- STOP mid-byte discards the partial byte: no register change, no strobe.
- Pointer persists across transactions. A read with no pointer phase starts at the last pointer.
- General call (address 0) is not supported: it gets NACK and the block goes to IGNORE.
- In IGNORE and IDLE, i2c_sda_oe = 0 always.

Test Plan:
1. Reset, then START, 0x84 (addr 0x42, W), ptr 0x01, data 0xA5, STOP -> ACK on all three bytes; wr_strobe pulse with wr_index = 1; reg_flat[15:8] = 0xA5; busy returns to 0 after STOP.
2. Write ptr 0x03 with data 0x11, 0x22 (NUM_REGS = 4) -> reg3 = 0x11, reg0 = 0x22 (wrap); two wr_strobe pulses with indices 3 then 0.
3. Write ptr 0x02, repeated START, 0x85 (R), master ACK, ACK, NACK, STOP -> SDA drives reg2, reg3, reg0 MSB-first; SDA released after the NACK.
4. START with 0x90 (addr 0x48) -> no ACK (SDA released at 9th clock); busy = 0; registers unchanged; a following valid transfer to 0x42 works.
5. Pointer 0x07 with NUM_REGS = 4 -> NACK on pointer byte; following data bytes are not written; no wr_strobe.
6. STOP after 4 data bits, and separately reset_n low mid-RDATA -> no register change; i2c_sda_oe = 0 immediately; state IDLE; all regs 0 after the reset.
